// File: rtl/sha256_pkg.sv
// Shared types for the sha256 core and the requester scheduler in front of it.
//   ShaContext  : job descriptor handed to the core on ctx_vld/ctx_rdy
//   SchedState  : scheduler FSM encoding
//   SHA_SCHED_TIMEOUT_DEFAULT : default per-job watchdog, in core-busy cycles
package sha256_pkg;

    typedef struct packed {
        logic [31:0] msg_addr;     // job-relative start of the message
        logic [31:0] msg_len;      // message length in bytes
        logic [31:0] digest_addr;  // job-relative digest destination
        logic [7:0]  flags;        // core mode bits, passed through untouched
    } ShaContext;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        RUN,
        DONE,
        ABORT,
        DRAIN
    } SchedState;

    localparam int SHA_SCHED_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after ptr, wrapping at N_REQ.
//   req       in   N_REQ  request vector
//   ptr       in   ID_W   highest-priority index this round (< N_REQ)
//   grant     out  N_REQ  one-hot grant, zero when no request
//   grant_idx out  ID_W   index of the granted request
//   grant_vld out  1      at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_vld
);

    // One extra bit so ptr + offset cannot overflow before the wrap compare.
    localparam logic [ID_W:0] N_WIDE = (ID_W+1)'(N_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            idx = sum[ID_W-1:0];
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_sched.sv
// Round-robin scheduler sharing one sha256 core between N_REQ requesters.
//   clk, rst_n      clock, async active-low reset
//   req_vld/req_rdy per-requester context handshake (req_rdy one-hot, IDLE only)
//   req_ctx         per-requester ShaContext
//   req_base        per-requester memory base byte address
//   done / err      one-cycle pulses to the owner: normal finish / watchdog abort
//   core_ctx_vld/core_ctx_rdy/core_ctx   issue port to the core
//   core_mem_addr   job-relative address from the core
//   mem_addr        core_mem_addr relocated by the owner's base (mod 2^32)
//   busy            a job is owned (stays high through an abort drain)
//   owner           current / last granted requester
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no job; arbitrate req_vld, latch winner's context and base
// ISSUE    | core_ctx_vld high, context held until the core accepts
// WAIT_LOW | accepted; wait for core to drop ctx_rdy (2 cycles high = empty job)
// RUN      | core hashing; watchdog counting
// DONE     | done pulse to owner, release
// ABORT    | err pulse to owner after watchdog expiry
// DRAIN    | aborted job still running in the core; wait for it to go idle
module sha256_sched
    import sha256_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = SHA_SCHED_TIMEOUT_DEFAULT,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_vld,
    output logic [N_REQ-1:0]       req_rdy,
    input  ShaContext [N_REQ-1:0]  req_ctx,
    input  logic [N_REQ-1:0][31:0] req_base,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       err,
    output logic                   core_ctx_vld,
    input  logic                   core_ctx_rdy,
    output ShaContext              core_ctx,
    input  logic [31:0]            core_mem_addr,
    output logic [31:0]            mem_addr,
    output logic                   busy,
    output logic [ID_W-1:0]        owner
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    SchedState        state;
    logic [ID_W-1:0]  rr_ptr;
    logic [31:0]      base_q;
    logic [TMR_W-1:0] timer;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_vld;
    logic [N_REQ-1:0] owner_oh;
    logic [ID_W-1:0]  next_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_vld),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Grant is visible to requesters only while arbitrating.
    assign req_rdy  = (state == IDLE) ? grant : '0;
    assign mem_addr = core_mem_addr + base_q;
    assign owner_oh = N_REQ'(1) << owner;
    // Finished owner drops to lowest priority next round.
    assign next_ptr = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            base_q       <= '0;
            timer        <= '0;
            core_ctx     <= '0;
            core_ctx_vld <= 1'b0;
            busy         <= 1'b0;
            done         <= '0;
            err          <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        core_ctx     <= req_ctx[grant_idx];
                        base_q       <= req_base[grant_idx];
                        owner        <= grant_idx;
                        busy         <= 1'b1;
                        core_ctx_vld <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (core_ctx_rdy) begin
                        core_ctx_vld <= 1'b0;
                        timer        <= '0;
                        state        <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    // Timer runs from accept so the watchdog covers this state too.
                    timer <= timer + TMR_W'(1);
                    if (!core_ctx_rdy) begin
                        state <= RUN;
                    end else if (timer == TMR_W'(1)) begin
                        done  <= owner_oh;
                        state <= DONE;
                    end
                end
                RUN: begin
                    timer <= timer + TMR_W'(1);
                    if (core_ctx_rdy) begin
                        done  <= owner_oh;
                        state <= DONE;
                    end else if (timer == TMR_LAST) begin
                        err   <= owner_oh;
                        state <= ABORT;
                    end
                end
                DONE: begin
                    rr_ptr <= next_ptr;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                ABORT: begin
                    rr_ptr <= next_ptr;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    // The core cannot be reset from here; it must finish on its own.
                    if (core_ctx_rdy) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_sched.sv
module tb_sha256_sched;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]        req_vld, req_rdy, done, err;
    ShaContext [3:0]   req_ctx;
    logic [3:0][31:0]  req_base;
    logic              core_ctx_vld, core_rdy;
    ShaContext         core_ctx;
    logic [31:0]       core_mem_addr, mem_addr;
    logic              busy;
    logic [1:0]        owner;

    logic [3:0]        req_vld_t, req_rdy_t, done_t, err_t;
    logic              core_ctx_vld_t, core_rdy_t;
    ShaContext         core_ctx_t;
    logic [31:0]       mem_addr_t;
    logic              busy_t;
    logic [1:0]        owner_t;

    sha256_sched #(.N_REQ(4), .TIMEOUT(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_ctx(req_ctx), .req_base(req_base),
        .done(done), .err(err),
        .core_ctx_vld(core_ctx_vld), .core_ctx_rdy(core_rdy), .core_ctx(core_ctx),
        .core_mem_addr(core_mem_addr), .mem_addr(mem_addr),
        .busy(busy), .owner(owner)
    );

    sha256_sched #(.N_REQ(4), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld_t), .req_rdy(req_rdy_t), .req_ctx(req_ctx), .req_base(req_base),
        .done(done_t), .err(err_t),
        .core_ctx_vld(core_ctx_vld_t), .core_ctx_rdy(core_rdy_t), .core_ctx(core_ctx_t),
        .core_mem_addr(core_mem_addr), .mem_addr(mem_addr_t),
        .busy(busy_t), .owner(owner_t)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int busy_len = 20;
    int busy_left = 0;

    int gq[$], gc[$], dq[$], dc[$];
    int multi_hot = 0;
    int err_seen = 0;

    localparam ShaContext CTX_A = '{msg_addr:32'h0000_2000, msg_len:32'd64,
                                    digest_addr:32'h0000_2100, flags:8'h5A};
    localparam ShaContext CTX_B = '{msg_addr:32'h0000_3000, msg_len:32'd128,
                                    digest_addr:32'h0000_3100, flags:8'hA5};

    // Core model for the main instance: after accept, ctx_rdy is low for busy_len cycles.
    task automatic tick();
        logic acc;
        acc = core_ctx_vld && core_rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            busy_left = busy_len;
            core_rdy  = (busy_len == 0);
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) core_rdy = 1'b1;
        end
    endtask

    task automatic clear_log();
        gq.delete(); gc.delete(); dq.delete(); dc.delete();
        multi_hot = 0;
        err_seen  = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if ($countones(req_rdy) > 1 || $countones(done) > 1 || $countones(err) > 1)
                multi_hot++;
            for (int b = 0; b < 4; b++) begin
                if (req_rdy[b]) begin gq.push_back(b); gc.push_back(cyc); end
                if (done[b])    begin dq.push_back(b); dc.push_back(cyc); end
            end
            if (err != 4'b0) err_seen++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (req_rdy !== 4'b0) begin miscompares++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy); end
        vectors++; if (done !== 4'b0 || err !== 4'b0) begin miscompares++; $display("FAIL reset_done_err: got %b/%b expected 0000/0000", done, err); end
        vectors++; if (core_ctx_vld !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_vld_busy: got %b/%b expected 0/0", core_ctx_vld, busy); end
        vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        vectors++; if (core_ctx !== ShaContext'('0)) begin miscompares++; $display("FAIL reset_core_ctx: got %h expected 0", core_ctx); end
        vectors++; if (busy_t !== 1'b0 || core_ctx_vld_t !== 1'b0) begin miscompares++; $display("FAIL reset_to_inst: got %b/%b expected 0/0", busy_t, core_ctx_vld_t); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] a;
        busy_len = 20;
        req_ctx[2]  = CTX_A;
        req_base[2] = 32'h0000_1000;
        req_vld     = 4'b0100;
        #1;
        vectors++; if (req_rdy !== 4'b0100) begin miscompares++; $display("FAIL single_req_rdy_t0: got %b expected 0100", req_rdy); end
        tick();
        req_vld = 4'b0;
        #1;
        vectors++; if (core_ctx_vld !== 1'b1) begin miscompares++; $display("FAIL single_vld_t1: got %b expected 1", core_ctx_vld); end
        vectors++; if (core_ctx !== CTX_A || owner !== 2'd2) begin miscompares++; $display("FAIL single_ctx_owner: got %h/%0d expected %h/2", core_ctx, owner, CTX_A); end
        vectors++; if (req_rdy !== 4'b0) begin miscompares++; $display("FAIL single_req_rdy_t1: got %b expected 0000", req_rdy); end
        tick();  // accept happened at the edge just passed
        for (int k = 1; k <= 25; k++) begin
            a = 32'(k) * 32'h40 + 32'h4;
            core_mem_addr = a;
            #1;
            if (k == 1) begin
                vectors++; if (core_ctx_vld !== 1'b0) begin miscompares++; $display("FAIL single_vld_drop: got %b expected 0", core_ctx_vld); end
            end
            vectors++; if (done !== ((k == 22) ? 4'b0100 : 4'b0000)) begin miscompares++; $display("FAIL single_done k=%0d: got %b expected %b", k, done, (k == 22) ? 4'b0100 : 4'b0000); end
            vectors++; if (err !== 4'b0) begin miscompares++; $display("FAIL single_err k=%0d: got %b expected 0000", k, err); end
            vectors++; if (busy !== (k <= 22)) begin miscompares++; $display("FAIL single_busy k=%0d: got %b expected %b", k, busy, (k <= 22)); end
            if (k <= 22) begin
                vectors++; if (mem_addr !== 32'h0000_1000 + a) begin miscompares++; $display("FAIL single_mem_addr k=%0d: got %h expected %h", k, mem_addr, 32'h0000_1000 + a); end
            end
            tick();
        end
    endtask

    task automatic test_rr_ptr();
        int exp_g[3] = '{3, 1, 3};
        busy_len = 3;
        req_ctx[1] = CTX_B;
        req_ctx[3] = CTX_A;
        clear_log();
        req_vld = 4'b1010;
        run_cycles(16);
        req_vld = 4'b0;
        run_cycles(12);
        vectors++; if (gq.size() != 3) begin miscompares++; $display("FAIL rr_grant_count: got %0d expected 3", gq.size()); end
        for (int i = 0; i < 3 && i < gq.size(); i++) begin
            vectors++; if (gq[i] != exp_g[i]) begin miscompares++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, gq[i], exp_g[i]); end
        end
        vectors++; if (dq.size() != 3 || dq[0] != 3) begin miscompares++; $display("FAIL rr_first_done: got n=%0d expected 3 dones, first from 3", dq.size()); end
        if (dc.size() > 0 && gc.size() > 1) begin
            vectors++; if (dc[0] >= gc[1]) begin miscompares++; $display("FAIL rr_done_before_grant: got done@%0d grant@%0d expected done earlier", dc[0], gc[1]); end
        end
    endtask

    task automatic test_all_four();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        busy_left = 0;
        core_rdy  = 1'b1;
        tick();
        busy_len = 2;
        for (int b = 0; b < 4; b++) req_base[b] = 32'h1000 * 32'(b + 1);
        clear_log();
        req_vld = 4'b1111;
        run_cycles(26);
        req_vld = 4'b0;
        run_cycles(10);
        vectors++; if (gq.size() != 5 || dq.size() != 5) begin miscompares++; $display("FAIL all4_counts: got %0d grants %0d dones expected 5/5", gq.size(), dq.size()); end
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            vectors++; if (gq[i] != exp_g[i]) begin miscompares++; $display("FAIL all4_grant_%0d: got %0d expected %0d", i, gq[i], exp_g[i]); end
        end
        for (int i = 0; i < 4 && i + 1 < gc.size() && i < dc.size(); i++) begin
            vectors++; if (dq[i] != gq[i] || dc[i] >= gc[i+1]) begin miscompares++; $display("FAIL all4_overlap_%0d: got done %0d@%0d next grant@%0d expected done %0d before it", i, dq[i], dc[i], gc[i+1], gq[i]); end
        end
        if (gc.size() > 0 && dc.size() > 0) begin
            vectors++; if (dc[0] - gc[0] != 5) begin miscompares++; $display("FAIL all4_latency: got %0d expected 5", dc[0] - gc[0]); end
        end
        vectors++; if (multi_hot != 0 || err_seen != 0) begin miscompares++; $display("FAIL all4_onehot_err: got %0d/%0d expected 0/0", multi_hot, err_seen); end
    endtask

    task automatic test_stall();
        busy_len   = 2;
        core_rdy   = 1'b0;
        req_ctx[0] = CTX_A;
        req_vld    = 4'b0001;
        #1;
        vectors++; if (req_rdy !== 4'b0001) begin miscompares++; $display("FAIL stall_req_rdy: got %b expected 0001", req_rdy); end
        tick();
        req_vld    = 4'b0;
        req_ctx[0] = CTX_B;
        for (int j = 1; j <= 6; j++) begin
            if (j == 6) core_rdy = 1'b1;
            #1;
            vectors++; if (core_ctx_vld !== 1'b1 || core_ctx !== CTX_A) begin miscompares++; $display("FAIL stall_hold_%0d: got %b/%h expected 1/%h", j, core_ctx_vld, core_ctx, CTX_A); end
            tick();
        end
        #1;
        vectors++; if (core_ctx_vld !== 1'b0) begin miscompares++; $display("FAIL stall_accept: got %b expected 0", core_ctx_vld); end
        clear_log();
        run_cycles(8);
        vectors++; if (dq.size() != 1 || dq[0] != 0) begin miscompares++; $display("FAIL stall_done: got %0d dones expected one from 0", dq.size()); end
    endtask

    task automatic test_timeout();
        logic [3:0] e;
        core_rdy_t = 1'b1;
        req_vld_t  = 4'b0100;
        #1;
        vectors++; if (req_rdy_t !== 4'b0100) begin miscompares++; $display("FAIL to_req_rdy: got %b expected 0100", req_rdy_t); end
        tick();
        req_vld_t = 4'b0;
        #1;
        vectors++; if (core_ctx_vld_t !== 1'b1 || owner_t !== 2'd2) begin miscompares++; $display("FAIL to_issue: got %b/%0d expected 1/2", core_ctx_vld_t, owner_t); end
        tick();  // accept
        for (int k = 1; k <= 47; k++) begin
            core_rdy_t = (k >= 40);
            req_vld_t  = (k >= 10 && k <= 41) ? 4'b0001 : 4'b0000;
            #1;
            e = (k == 17) ? 4'b0100 : 4'b0000;
            vectors++; if (err_t !== e) begin miscompares++; $display("FAIL to_err k=%0d: got %b expected %b", k, err_t, e); end
            e = (k == 45) ? 4'b0001 : 4'b0000;
            vectors++; if (done_t !== e) begin miscompares++; $display("FAIL to_done k=%0d: got %b expected %b", k, done_t, e); end
            vectors++; if (busy_t !== ((k <= 40) || (k >= 42 && k <= 45))) begin miscompares++; $display("FAIL to_busy k=%0d: got %b", k, busy_t); end
            if (k <= 41) begin
                e = (k == 41) ? 4'b0001 : 4'b0000;
                vectors++; if (req_rdy_t !== e) begin miscompares++; $display("FAIL to_req_rdy k=%0d: got %b expected %b", k, req_rdy_t, e); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_job();
        busy_len = 20;
        req_vld  = 4'b0010;
        tick();
        req_vld = 4'b0;
        repeat (5) tick();
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (req_rdy !== 4'b0 || done !== 4'b0 || err !== 4'b0) begin miscompares++; $display("FAIL rst_mid_pulses: got %b/%b/%b expected zeros", req_rdy, done, err); end
        vectors++; if (core_ctx_vld !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin miscompares++; $display("FAIL rst_mid_state: got %b/%b/%0d expected 0/0/0", core_ctx_vld, busy, owner); end
        vectors++; if (core_ctx !== ShaContext'('0)) begin miscompares++; $display("FAIL rst_mid_ctx: got %h expected 0", core_ctx); end
        #2 rst_n = 1'b1;
        busy_left = 0;
        core_rdy  = 1'b1;
        clear_log();
        run_cycles(4);
        vectors++; if (dq.size() != 0 || err_seen != 0) begin miscompares++; $display("FAIL rst_mid_no_pulse: got %0d dones %0d errs expected 0/0", dq.size(), err_seen); end
        req_base[0] = 32'hFFFF_FFF0;
        req_vld     = 4'b0001;
        #1;
        vectors++; if (req_rdy !== 4'b0001) begin miscompares++; $display("FAIL rst_fresh_rdy: got %b expected 0001", req_rdy); end
        tick();
        req_vld = 4'b0;
        #1;
        vectors++; if (core_ctx_vld !== 1'b1 || owner !== 2'd0) begin miscompares++; $display("FAIL rst_fresh_issue: got %b/%0d expected 1/0", core_ctx_vld, owner); end
        tick();
        core_mem_addr = 32'h20;
        #1;
        vectors++; if (mem_addr !== 32'h10 || busy !== 1'b1) begin miscompares++; $display("FAIL rst_wrap_addr: got %h/%b expected 00000010/1", mem_addr, busy); end
        clear_log();
        run_cycles(30);
        vectors++; if (dq.size() != 1 || err_seen != 0) begin miscompares++; $display("FAIL rst_fresh_done: got %0d dones %0d errs expected 1/0", dq.size(), err_seen); end
    endtask

    initial begin
        rst_n         = 1'b0;
        req_vld       = 4'b0;
        req_vld_t     = 4'b0;
        req_ctx       = '0;
        req_base      = '0;
        core_rdy      = 1'b1;
        core_rdy_t    = 1'b1;
        core_mem_addr = 32'h0;
        test_reset();
        test_single();
        test_rr_ptr();
        test_all_four();
        test_stall();
        test_timeout();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
